// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares the single-port, synchronous-read frame-buffer RAM
// between VGA scan-out (strict priority, fixed 2-cycle latency) and the
// processor bus (pulse request / ack, one-entry request buffer).
//
// CPU FSM states
//   state | meaning
//   IDLE  | no CPU request in flight; a CPU_REQ is captured here
//   PEND  | request buffered, waiting for a cycle with no VGA fetch
//   DATA  | RAM accessed last cycle; read data arrives, ack issued next
module fb_access_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic [DATA_W-1:0] vga_data_o,
    output logic              vga_valid_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              overrun_o,
    output logic              starve_o,
    output logic [15:0]       stall_cnt_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [15:0]         stall_q, stall_d;
    logic                ovr_q, ovr_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                vga_rd_q;
    logic                vga_valid_q;
    logic [DATA_W-1:0]   vga_data_q;

    // CPU request FSM: capture, wait for a free RAM cycle, return data/ack
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        stall_d = stall_q;
        ovr_d   = ovr_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (vga_req_i) begin
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                    if (wait_q != WAIT_MAX)  wait_d  = wait_q + 1'b1;
                end else begin
                    // Cleared on the grant so STARVE drops the following cycle.
                    wait_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!we_q) rdata_d = mem_rdata_i;
                ack_d   = 1'b1;
                wait_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Only one request can be buffered; anything arriving meanwhile is lost.
        if (cpu_req_i && (state_q != IDLE)) ovr_d = 1'b1;
    end

    // CPU FSM and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            stall_q <= '0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM port mux: VGA always wins, the buffered CPU access fills idle slots
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (vga_req_i) begin
            mem_en_o   = 1'b1;
            mem_addr_o = vga_addr_i;
        end else if (state_q == PEND) begin
            mem_en_o = 1'b1;
            mem_we_o = we_q;
        end
    end

    // VGA ownership/valid pipeline: tag the read, then register the RAM data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vga_rd_q    <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
        end else begin
            vga_rd_q    <= vga_req_i;
            vga_valid_q <= vga_rd_q;
            if (vga_rd_q) vga_data_q <= mem_rdata_i;
        end
    end

    assign vga_data_o  = vga_data_q;
    assign vga_valid_o = vga_valid_q;
    assign cpu_ack_o   = ack_q;
    assign cpu_rdata_o = rdata_q;
    assign overrun_o   = ovr_q;
    assign starve_o    = (wait_q == WAIT_MAX);
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: a RAM model plus a transaction-level reference
// (request time, first free cycle, ack two cycles later) checked every cycle.
module tb_fb_access_arbiter;

    localparam int LIMIT = 64;

    logic        clk, rst_n;
    logic        vga_req, cpu_req, cpu_we;
    logic [14:0] vga_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  vga_data, cpu_rdata, mem_wdata, mem_rdata;
    logic        vga_valid, cpu_ack, overrun, starve, mem_en, mem_we;
    logic [15:0] stall_cnt;
    logic [14:0] mem_addr;

    logic        ld_en;
    logic [14:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  ram [0:32767];

    fb_access_arbiter #(.ADDR_W(15), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .vga_req_i(vga_req), .vga_addr_i(vga_addr),
        .vga_data_o(vga_data), .vga_valid_o(vga_valid),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
        .overrun_o(overrun), .starve_o(starve), .stall_cnt_o(stall_cnt),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read single-port frame buffer, with a bench-side load port
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_cnt = 0;
    int last_ack_cyc = -1;
    int valid_cnt = 0;

    // reference state
    logic [7:0]  mmem [0:32767];
    logic        m_act, m_gnt, m_we, m_ovr;
    int          m_t, m_gnt_c, m_blk, m_stall;
    logic [14:0] m_addr;
    logic [7:0]  m_wd, m_rd, e_rdata, e_vdata;
    logic        vq1, vq2;
    logic [7:0]  vd1, vd2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_gnt = 0; m_we = 0; m_ovr = 0;
        m_t = 0; m_gnt_c = 0; m_blk = 0; m_stall = 0;
        m_addr = '0; m_wd = '0; m_rd = '0;
        e_rdata = '0; e_vdata = '0;
        vq1 = 0; vq2 = 0; vd1 = '0; vd2 = '0;
    endtask

    // Hold reset for three cycles under random inputs, checking cleared outputs.
    task automatic do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst_n = 0; ld_en = 0;
            vga_req = 1'($urandom); vga_addr = 15'($urandom);
            cpu_req = 1'($urandom); cpu_we = 1'($urandom);
            cpu_addr = 15'($urandom); cpu_wdata = 8'($urandom);
            #1;
            chk("rst_valid", vga_valid, 0);
            chk("rst_vdata", vga_data, 0);
            chk("rst_ack", cpu_ack, 0);
            chk("rst_rdata", cpu_rdata, 0);
            chk("rst_ovr", overrun, 0);
            chk("rst_stall", stall_cnt, 0);
            chk("rst_starve", starve, 0);
            chk("rst_memen", mem_en, vga_req);
            chk("rst_memwe", mem_we, 0);
            cyc++;
        end
        model_reset();
    endtask

    // One clock cycle: drive inputs, predict and compare every output.
    task automatic step(input logic vreq, input logic [14:0] vaddr, input logic creq,
                        input logic cwe, input logic [14:0] caddr, input logic [7:0] cwd);
        logic e_ack, e_starve, e_en, e_we, pend, cpu_gnt;
        logic [14:0] e_addr;
        @(negedge clk);
        rst_n = 1; ld_en = 0;
        vga_req = vreq; vga_addr = vaddr;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        #1;
        if (vq2) e_vdata = vd2;
        e_ack = m_act && m_gnt && (cyc == m_gnt_c + 2);
        if (e_ack) begin
            if (!m_we) e_rdata = m_rd;
            m_act = 0;
        end
        e_starve = m_act && !m_gnt && (cyc > m_t) && (m_blk >= LIMIT);
        chk("vga_valid", vga_valid, vq2);
        chk("vga_data", vga_data, e_vdata);
        chk("cpu_ack", cpu_ack, e_ack);
        chk("cpu_rdata", cpu_rdata, e_rdata);
        chk("overrun", overrun, m_ovr);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("starve", starve, e_starve);
        pend = m_act && !m_gnt && (cyc > m_t);
        cpu_gnt = 0;
        e_addr = '0;
        if (vreq) begin
            e_en = 1; e_we = 0; e_addr = vaddr;
            if (pend) begin
                m_blk++;
                if (m_stall < 65535) m_stall++;
            end
        end else if (pend) begin
            e_en = 1; e_we = m_we; e_addr = m_addr;
            cpu_gnt = 1; m_gnt = 1; m_gnt_c = cyc;
            if (m_we) mmem[m_addr] = m_wd;
            else      m_rd = mmem[m_addr];
        end else begin
            e_en = 0; e_we = 0;
        end
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (cpu_gnt && e_we) chk("mem_wdata", mem_wdata, m_wd);
        if (creq) begin
            if (!m_act) begin
                m_act = 1; m_gnt = 0; m_t = cyc; m_blk = 0;
                m_we = cwe; m_addr = caddr; m_wd = cwd;
            end else m_ovr = 1;
        end
        if (cpu_ack) begin
            ack_cnt++;
            last_ack_cyc = cyc;
        end
        if (vga_valid) valid_cnt++;
        vq2 = vq1; vd2 = vd1;
        vq1 = vreq; vd1 = vreq ? mmem[vaddr] : 8'h00;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0);
    endtask

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  wd;
        int          hold;
        int          lat;
        logic [7:0]  rd;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int c0, a0, v0, first_st, burst;
        logic st_gnt, st_after;
        tbl[0] = '{we:1'b1, addr:15'h0020, wd:8'h3C, hold:0,  lat:3,  rd:8'h00};
        tbl[1] = '{we:1'b0, addr:15'h0020, wd:8'h00, hold:0,  lat:3,  rd:8'h3C};
        tbl[2] = '{we:1'b0, addr:15'h0020, wd:8'h00, hold:10, lat:13, rd:8'h3C};
        tbl[3] = '{we:1'b1, addr:15'h0030, wd:8'h77, hold:2,  lat:5,  rd:8'h00};
        tbl[4] = '{we:1'b0, addr:15'h0030, wd:8'h00, hold:1,  lat:4,  rd:8'h77};

        rst_n = 0; ld_en = 0;
        vga_req = 0; vga_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ld_addr = '0; ld_data = '0;
        model_reset();

        // preload RAM[0..127]; RAM[0x10] = 0xA5
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            ld_en = 1; ld_addr = 15'(i);
            ld_data = (i == 16) ? 8'hA5 : 8'($urandom);
            mmem[i] = ld_data;
        end
        do_reset();

        // single VGA fetch, latency 2
        step(1, 15'h0010, 0, 0, '0, '0);
        idle(1);
        chk("vga_n1_valid", vga_valid, 0);
        idle(1);
        chk("vga_a5_valid", vga_valid, 1);
        chk("vga_a5_data", vga_data, 8'hA5);

        // continuous 100-cycle stream
        v0 = valid_cnt;
        for (int i = 0; i < 100; i++) step(1, 15'(i), 0, 0, '0, '0);
        idle(3);
        chk("stream_cnt", valid_cnt - v0, 100);

        // table of CPU transactions with VGA contention
        do_reset();
        for (int i = 0; i < 5; i++) begin
            c0 = cyc; a0 = ack_cnt;
            step(0, '0, 1, tbl[i].we, tbl[i].addr, tbl[i].wd);
            for (int k = 1; k <= tbl[i].hold; k++) step(1, 15'(k), 0, 0, '0, '0);
            for (int j = 0; j < 30; j++) begin
                if (ack_cnt != a0) break;
                step(0, '0, 0, 0, '0, '0);
            end
            chk("tbl_ack_seen", ack_cnt - a0, 1);
            chk("tbl_latency", last_ack_cyc - c0, tbl[i].lat);
            if (!tbl[i].we) chk("tbl_rdata", cpu_rdata, tbl[i].rd);
        end
        chk("tbl_stall", stall_cnt, 13);
        chk("tbl_ovr", overrun, 0);

        // write then read issued in the ack cycle
        c0 = cyc;
        step(0, '0, 1, 1, 15'h0041, 8'hC3);
        step(0, '0, 0, 0, '0, '0);
        chk("b2b_memwe", mem_we, 1);
        step(0, '0, 0, 0, '0, '0);
        step(0, '0, 1, 0, 15'h0041, '0);
        chk("b2b_wr_ack", last_ack_cyc, c0 + 3);
        a0 = ack_cnt;
        for (int j = 0; j < 10; j++) begin
            if (ack_cnt != a0) break;
            step(0, '0, 0, 0, '0, '0);
        end
        chk("b2b_rd_ack", last_ack_cyc, c0 + 6);
        chk("b2b_rdata", cpu_rdata, 8'hC3);
        chk("b2b_ovr", overrun, 0);

        // starvation: 70 blocked cycles
        do_reset();
        c0 = cyc; first_st = -1;
        step(0, '0, 1, 0, 15'h0020, '0);
        for (int k = 1; k <= 70; k++) begin
            step(1, 15'(k), 0, 0, '0, '0);
            if (starve && first_st < 0) first_st = cyc - 1 - c0;
        end
        step(0, '0, 0, 0, '0, '0);
        st_gnt = starve;
        step(0, '0, 0, 0, '0, '0);
        st_after = starve;
        chk("starve_rise", first_st, 65);
        chk("starve_at_gnt", st_gnt, 1);
        chk("starve_drop", st_after, 0);
        idle(2);
        chk("starve_stall", stall_cnt, 70);
        chk("starve_ack", last_ack_cyc, c0 + 73);

        // overrun: second request while pending
        do_reset();
        a0 = ack_cnt;
        step(0, '0, 1, 0, 15'h0030, '0);
        step(1, 15'h0001, 0, 0, '0, '0);
        step(1, 15'h0002, 1, 1, 15'h0031, 8'hEE);
        step(1, 15'h0003, 0, 0, '0, '0);
        idle(8);
        chk("ovr_set", overrun, 1);
        chk("ovr_one_ack", ack_cnt - a0, 1);

        // async reset while pending
        step(0, '0, 1, 0, 15'h0022, '0);
        step(1, 15'h0005, 0, 0, '0, '0);
        step(1, 15'h0006, 0, 0, '0, '0);
        do_reset();
        a0 = ack_cnt;
        idle(6);
        chk("rst_pend_noack", ack_cnt - a0, 0);
        chk("rst_pend_ovr", overrun, 0);
        chk("rst_pend_stall", stall_cnt, 0);

        // randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic vr;
            if (i == 1500) do_reset();
            if (burst > 0) begin
                vr = 1; burst--;
            end else begin
                vr = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 199) == 0) burst = $urandom_range(60, 80);
            end
            step(vr, 15'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0),
                 1'($urandom), 15'($urandom_range(0, 127)), 8'($urandom));
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
